// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolve feeder path: the feeder FSM state
// encoding, default image geometry, stride codes and the physical line-buffer
// lookup used by the row map.
// ---------------------------------------------------------------------------
package conv_pkg;

  // Default image geometry
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // Stride codes as seen on the stride input
  localparam logic [1:0] STRIDE1 = 2'd1;
  localparam logic [1:0] STRIDE2 = 2'd2;

  // Logical load-row value meaning "all rows of this load have been issued"
  localparam logic [1:0] LOAD_ROW_END = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_READY,
    ST_RELOAD,
    ST_DRAIN_R,
    ST_DONE
  } feeder_state_t;

  // Physical buffer holding logical window row idx, given the rotating
  // pointer ptr (the physical buffer currently holding the top row).
  function automatic logic [1:0] phys_buf(input logic [1:0] ptr,
                                          input logic [1:0] idx);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, idx};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// ---------------------------------------------------------------------------
// line_buffer_ram
// One image row of pixel storage: synchronous write, asynchronous read.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write column
//   wdata  in   write pixel
//   raddr  in   read column
//   rdata  out  pixel at raddr (combinational)
// ---------------------------------------------------------------------------
module line_buffer_ram #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; contents only matter once a load has completed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_line_feeder.sv
// ---------------------------------------------------------------------------
// conv_line_feeder
// Source-side feeder for the convolve engine. Loads three image rows from
// source memory into line buffers and presents one 3-row column per cycle,
// advancing on shift_buffer and sliding the window down by the stride on
// row_next.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           begin frame (IDLE only); latches stride and src_base_addr
//   stride          2 = stride 2, anything else = stride 1
//   src_base_addr   frame base address in source memory
//   shift_buffer    advance one column (READY only)
//   row_next        advance window by stride rows (READY only)
//   src_rd_en       source read strobe
//   src_rd_addr     base + row*IMG_W + col
//   src_rd_data     read data, valid one cycle after src_rd_en
//   in_l1/2/3       top/middle/bottom pixel of the current column
//   ready           column data valid
//   done            one-cycle pulse when the frame is exhausted
//   col_err         sticky: shift requested at the last column
// ---------------------------------------------------------------------------
module conv_line_feeder
  import conv_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic [ADDR_W-1:0]    src_base_addr,
  input  logic                 shift_buffer,
  input  logic                 row_next,
  output logic                 src_rd_en,
  output logic [ADDR_W-1:0]    src_rd_addr,
  input  logic [BIT_DEPTH-1:0] src_rd_data,
  output logic [BIT_DEPTH-1:0] in_l1,
  output logic [BIT_DEPTH-1:0] in_l2,
  output logic [BIT_DEPTH-1:0] in_l3,
  output logic                 ready,
  output logic                 done,
  output logic                 col_err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  feeder_state_t     state;
  logic              stride_two;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  top_row;
  logic [COL_W-1:0]  col;
  logic [1:0]        row_ptr;
  logic [1:0]        load_row;
  logic [COL_W-1:0]  load_col;

  // Buffer/column tags travelling with an issued read
  logic [1:0]        rd_buf;
  logic [COL_W-1:0]  rd_col;
  logic              wr_valid;
  logic [1:0]        wr_buf;
  logic [COL_W-1:0]  wr_col;

  logic [1:0]        step;
  logic [ADDR_W-1:0] src_row;
  logic [ADDR_W-1:0] next_addr;
  logic              frame_end;

  logic [BIT_DEPTH-1:0] buf_q [3];

  assign step      = stride_two ? STRIDE2 : STRIDE1;
  assign src_row   = ADDR_W'(top_row) + ADDR_W'(load_row);
  assign next_addr = base_q + src_row * ADDR_W'(IMG_W) + ADDR_W'(load_col);
  assign frame_end = (int'(top_row) + int'(step) + 2) > (IMG_H - 1);

  // Main controller: frame sequencing, read issue, column/row counters and
  // the row map. A load walks logical rows load_row..2, one column per cycle;
  // load_row reaching LOAD_ROW_END means the last read has been issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      stride_two  <= 1'b0;
      base_q      <= '0;
      top_row     <= '0;
      col         <= '0;
      row_ptr     <= '0;
      load_row    <= '0;
      load_col    <= '0;
      rd_buf      <= '0;
      rd_col      <= '0;
      src_rd_en   <= 1'b0;
      src_rd_addr <= '0;
      ready       <= 1'b0;
      done        <= 1'b0;
      col_err     <= 1'b0;
    end else begin
      src_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            stride_two <= (stride == STRIDE2);
            base_q     <= src_base_addr;
            top_row    <= '0;
            col        <= '0;
            row_ptr    <= '0;
            load_row   <= '0;
            load_col   <= '0;
            state      <= ST_FILL;
          end
        end
        ST_FILL, ST_RELOAD: begin
          if (load_row != LOAD_ROW_END) begin
            src_rd_en   <= 1'b1;
            src_rd_addr <= next_addr;
            rd_buf      <= phys_buf(row_ptr, load_row);
            rd_col      <= load_col;
            if (load_col == COL_W'(IMG_W - 1)) begin
              load_col <= '0;
              load_row <= load_row + 2'd1;
            end else begin
              load_col <= load_col + 1'b1;
            end
          end else begin
            state <= (state == ST_FILL) ? ST_DRAIN : ST_DRAIN_R;
          end
        end
        ST_DRAIN, ST_DRAIN_R: begin
          state <= ST_READY;
          ready <= 1'b1;
        end
        ST_READY: begin
          if (row_next) begin
            ready <= 1'b0;
            if (frame_end) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              // Oldest rows are the first 'step' logical rows; after the
              // rotate they become the last 'step' rows, which get reloaded.
              col      <= '0;
              top_row  <= top_row + ROW_W'(step);
              row_ptr  <= phys_buf(row_ptr, step);
              load_row <= LOAD_ROW_END - step;
              load_col <= '0;
              state    <= ST_RELOAD;
            end
          end else if (shift_buffer) begin
            if (col == COL_W'(IMG_W - 1)) col_err <= 1'b1;
            else                          col     <= col + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write pipeline: memory returns data the cycle after the strobe, so the
  // destination tags are delayed one cycle to line up with src_rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_buf   <= '0;
      wr_col   <= '0;
    end else begin
      wr_valid <= src_rd_en;
      wr_buf   <= rd_buf;
      wr_col   <= rd_col;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_buf
    line_buffer_ram #(
      .DEPTH (IMG_W),
      .WIDTH (BIT_DEPTH),
      .AW    (COL_W)
    ) u_ram (
      .clk   (clk),
      .we    (wr_valid && (wr_buf == 2'(i))),
      .waddr (wr_col),
      .wdata (src_rd_data),
      .raddr (col),
      .rdata (buf_q[i])
    );
  end

  function automatic logic [BIT_DEPTH-1:0] sel_buf(input logic [1:0] p);
    case (p)
      2'd0:    return buf_q[0];
      2'd1:    return buf_q[1];
      default: return buf_q[2];
    endcase
  endfunction

  // Column output through the row map, forced to zero while not ready.
  always_comb begin
    in_l1 = '0;
    in_l2 = '0;
    in_l3 = '0;
    if (ready) begin
      in_l1 = sel_buf(phys_buf(row_ptr, 2'd0));
      in_l2 = sel_buf(phys_buf(row_ptr, 2'd1));
      in_l3 = sel_buf(phys_buf(row_ptr, 2'd2));
    end
  end

endmodule

// File: tb/tb_conv_line_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_line_feeder
// Self-checking bench for conv_line_feeder. Source memory returns the low
// byte of the address; expected pixels come from the window position
// (base, top row, column) tracked by a small model.
// ---------------------------------------------------------------------------
module tb_conv_line_feeder;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    stride = 2'd0;
  logic [AW-1:0] src_base_addr = '0;
  logic          shift_buffer = 1'b0;
  logic          row_next = 1'b0;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [7:0]    src_rd_data = 8'd0;
  logic [7:0]    in_l1, in_l2, in_l3;
  logic          ready, done, col_err;

  int testCount = 0;
  int failCount = 0;

  // Window model
  int m_base, m_top, m_col, m_s;
  bit m_err;

  conv_line_feeder #(
    .BIT_DEPTH (8),
    .IMG_W     (W),
    .IMG_H     (H),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stride        (stride),
    .src_base_addr (src_base_addr),
    .shift_buffer  (shift_buffer),
    .row_next      (row_next),
    .src_rd_en     (src_rd_en),
    .src_rd_addr   (src_rd_addr),
    .src_rd_data   (src_rd_data),
    .in_l1         (in_l1),
    .in_l2         (in_l2),
    .in_l3         (in_l3),
    .ready         (ready),
    .done          (done),
    .col_err       (col_err)
  );

  always #5 clk = ~clk;

  // Source memory: mem[a] = a[7:0], one-cycle read latency
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= src_rd_addr[7:0];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] px(input int rowOff);
    int a;
    a = (m_base + (m_top + rowOff) * W + m_col) % 1024;
    return 8'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkColumn(input string tag);
    checkOutput({tag, "_l1"}, 32'(in_l1), 32'(px(0)));
    checkOutput({tag, "_l2"}, 32'(in_l2), 32'(px(1)));
    checkOutput({tag, "_l3"}, 32'(in_l3), 32'(px(2)));
  endtask

  task automatic applyStimulus(input bit sh, input bit rn);
    shift_buffer = sh;
    row_next     = rn;
    @(negedge clk);
    shift_buffer = 1'b0;
    row_next     = 1'b0;
  endtask

  task automatic doShifts(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (m_col == W - 1) m_err = 1'b1;
      else                m_col++;
    end
  endtask

  // Waits for ready, wiggling shift/row_next meanwhile (they must be ignored).
  task automatic waitReady(output int cyc, output int reads);
    cyc = 0;
    reads = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (src_rd_en) reads++;
      if (ready) break;
      shift_buffer = 1'($urandom_range(0, 1));
      row_next     = 1'($urandom_range(0, 1));
    end
    shift_buffer = 1'b0;
    row_next     = 1'b0;
    checkOutput("wait_ready", 32'(ready), 1);
  endtask

  task automatic startFrame(input logic [1:0] st, input logic [AW-1:0] base);
    start         = 1'b1;
    stride        = st;
    src_base_addr = base;
    @(negedge clk);
    start         = 1'b0;
    stride        = 2'($urandom_range(0, 3));
    src_base_addr = AW'($urandom);
    m_base = int'(base);
    m_s    = (st == 2'd2) ? 2 : 1;
    m_top  = 0;
    m_col  = 0;
  endtask

  task automatic doRowNext(input bit sh, output bit fin);
    int cyc, rd;
    applyStimulus(sh, 1'b1);
    if (m_top + m_s + 2 > H - 1) begin
      fin = 1'b1;
      checkOutput("done_pulse", 32'(done), 1);
      checkOutput("done_ready", 32'(ready), 0);
      checkOutput("done_l1", 32'(in_l1), 0);
      @(negedge clk);
      checkOutput("done_clear", 32'(done), 0);
      checkOutput("idle_ready", 32'(ready), 0);
    end else begin
      fin = 1'b0;
      m_top += m_s;
      m_col = 0;
      waitReady(cyc, rd);
      checkOutput("reload_reads", 32'(rd), 32'(m_s * W));
      checkOutput("reload_latency", 32'(cyc), 32'(m_s * W + 2));
      checkColumn("reload");
    end
  endtask

  initial begin
    int cyc, rd, iter;
    bit fin;
    logic [1:0] st;

    m_err = 1'b0;
    m_base = 0; m_top = 0; m_col = 0; m_s = 1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_col_err", 32'(col_err), 0);
    checkOutput("rst_rd_en", 32'(src_rd_en), 0);
    checkOutput("rst_rd_addr", 32'(src_rd_addr), 0);
    checkOutput("rst_l1", 32'(in_l1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame A: base 0, stride 1
    startFrame(2'd1, '0);
    waitReady(cyc, rd);
    checkOutput("fill_latency", 32'(cyc), 86);
    checkOutput("fill_reads", 32'(rd), 84);
    checkColumn("first_col");
    doShifts(1);
    checkColumn("shift1");
    doShifts(26);
    checkColumn("hold27");
    checkOutput("hold_col_err", 32'(col_err), 0);
    // Shift and row_next together: reload wins, column restarts at 0
    doRowNext(1'b1, fin);
    iter = 0;
    while (!fin && iter < 40) begin
      doShifts($urandom_range(0, 6));
      checkColumn("randA");
      doRowNext(1'($urandom_range(0, 1)), fin);
      iter++;
    end
    checkOutput("frameA_top", 32'(m_top), 25);
    checkOutput("frameA_err", 32'(col_err), 32'(m_err));

    // Frame B: high base (address wrap), stride 2
    startFrame(2'd2, AW'($urandom_range(900, 1023)));
    waitReady(cyc, rd);
    checkOutput("fillB_latency", 32'(cyc), 86);
    checkOutput("fillB_reads", 32'(rd), 84);
    checkColumn("firstB");
    // start outside IDLE is ignored
    start = 1'b1;
    src_base_addr = AW'($urandom);
    @(negedge clk);
    start = 1'b0;
    checkColumn("start_ignored");
    checkOutput("start_ignored_rd", 32'(src_rd_en), 0);
    doShifts(29);
    checkColumn("stuck27");
    checkOutput("col_err_set", 32'(col_err), 1);
    iter = 0;
    fin = 1'b0;
    while (!fin && iter < 20) begin
      doRowNext(1'($urandom_range(0, 1)), fin);
      if (!fin) begin
        doShifts($urandom_range(0, 10));
        checkColumn("randB");
      end
      iter++;
    end
    checkOutput("frameB_top", 32'(m_top), 24);
    checkOutput("frameB_err", 32'(col_err), 1);

    // Frame C: reset at fill read #40, then restart
    st = 2'($urandom_range(0, 3));
    if (st == 2'd2) st = 2'd3;
    startFrame(st, AW'($urandom));
    rd = 0;
    cyc = 0;
    while (rd < 40 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (src_rd_en) rd++;
    end
    checkOutput("abort_reads", 32'(rd), 40);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(ready), 0);
    checkOutput("abort_rd_en", 32'(src_rd_en), 0);
    checkOutput("abort_rd_addr", 32'(src_rd_addr), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_col_err", 32'(col_err), 0);
    checkOutput("abort_l1", 32'(in_l1), 0);
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("no_autostart", 32'(src_rd_en), 0);
    checkOutput("no_autostart_ready", 32'(ready), 0);

    startFrame(st, AW'($urandom));
    waitReady(cyc, rd);
    checkOutput("refill_latency", 32'(cyc), 86);
    checkOutput("refill_reads", 32'(rd), 84);
    checkColumn("refill");
    doShifts($urandom_range(1, 20));
    checkColumn("randC");
    doRowNext(1'b0, fin);
    checkOutput("frameC_err", 32'(col_err), 32'(m_err));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
